// File: rtl/hello_world.sv
// rtl/hello_world.sv - byte-at-a-time fwrite(ptr, size, nmemb, stream) engine on a single memory bus
//
// Purpose:
//   While setb=0, captures a RISC-V-style argument frame every cycle.
//   Once setb=1, copies size*nmemb bytes from ptr to the fixed address stream.
//   Each byte costs one byte read and one byte write.
//   On completion it returns nmemb in a0 and raises idle.
//
// Ports:
//   clk, rstb              clock (rising edge), asynchronous active-low reset
//   setb                   0 = load/hold arguments, 1 = run
//   idle                   routine has returned
//   pc0, ra0, sp0, s00     entry pc, return address, stack pointer, saved s0
//   a00..a50               argument registers (ptr, size, nmemb, stream, unused, unused)
//   addr, size, valid,     bus request: address, transfer size (0 = byte), request,
//   write, wdata           direction (1 = write), write data
//   rdata, ready           word-aligned read data, slave accept (combinational)

module hello_world #(
    parameter int PCW  = 8,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            setb,
    output logic            idle,
    input  logic [PCW-1:0]  pc0,
    input  logic [XLEN-1:0] ra0,
    input  logic [XLEN-1:0] sp0,
    input  logic [XLEN-1:0] s00,
    input  logic [XLEN-1:0] a00,
    input  logic [XLEN-1:0] a10,
    input  logic [XLEN-1:0] a20,
    input  logic [XLEN-1:0] a30,
    input  logic [XLEN-1:0] a40,
    input  logic [XLEN-1:0] a50,
    output logic [31:0]     addr,
    output logic [2:0]      size,
    output logic            valid,
    output logic            write,
    output logic [31:0]     wdata,
    input  logic [31:0]     rdata,
    input  logic            ready
);

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_RD   = 3'd1,
        S_GAP1 = 3'd2,
        S_WR   = 3'd3,
        S_GAP2 = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [PCW-1:0]  pc_q, pc_d;
    logic [XLEN-1:0] ra_q, ra_d;
    logic [XLEN-1:0] sp_q, sp_d;
    logic [XLEN-1:0] s0_q, s0_d;
    logic [XLEN-1:0] a0_q, a0_d;
    logic [XLEN-1:0] a1_q, a1_d;
    logic [XLEN-1:0] a2_q, a2_d;
    logic [XLEN-1:0] a3_q, a3_d;
    logic [XLEN-1:0] a4_q, a4_d;
    logic [XLEN-1:0] a5_q, a5_d;
    logic [XLEN-1:0] total_q, total_d;
    logic [XLEN-1:0] i_q, i_d;
    logic [7:0]      data_byte_q, data_byte_d;

    // a0 holds ptr while running and the return value once DONE is reached.
    logic [XLEN-1:0] a0;
    assign a0 = a0_q;

    // Source address of the current byte; wraps modulo 2^XLEN.
    logic [XLEN-1:0] rd_addr;
    assign rd_addr = a0_q + i_q;

    // Stack pointer, s0, a4, a5 and the pc are architectural state only.
    logic unused_regs;
    assign unused_regs = ^{sp_q, s0_q, a4_q, a5_q, pc_q, ra_q};

    // State register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= S_LOAD;
            pc_q        <= '0;
            ra_q        <= '0;
            sp_q        <= '0;
            s0_q        <= '0;
            a0_q        <= '0;
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            a4_q        <= '0;
            a5_q        <= '0;
            total_q     <= '0;
            i_q         <= '0;
            data_byte_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ra_q        <= ra_d;
            sp_q        <= sp_d;
            s0_q        <= s0_d;
            a0_q        <= a0_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            a3_q        <= a3_d;
            a4_q        <= a4_d;
            a5_q        <= a5_d;
            total_q     <= total_d;
            i_q         <= i_d;
            data_byte_q <= data_byte_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ra_d        = ra_q;
        sp_d        = sp_q;
        s0_d        = s0_q;
        a0_d        = a0_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        a3_d        = a3_q;
        a4_d        = a4_q;
        a5_d        = a5_q;
        total_d     = total_q;
        i_d         = i_q;
        data_byte_d = data_byte_q;

        if (state_q != S_LOAD && !setb) begin
            // Abort: abandon whatever transfer is on the bus.
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (!setb) begin
                        pc_d = pc0;
                        ra_d = ra0;
                        sp_d = sp0;
                        s0_d = s00;
                        a0_d = a00;
                        a1_d = a10;
                        a2_d = a20;
                        a3_d = a30;
                        a4_d = a40;
                        a5_d = a50;
                    end else begin
                        total_d = a1_q * a2_q;
                        i_d     = '0;
                        if (total_d == '0) begin
                            // Nothing to write: return 0 straight away.
                            a0_d    = '0;
                            pc_d    = ra_q[PCW-1:0];
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (ready) begin
                        data_byte_d = rdata[{rd_addr[1:0], 3'b000} +: 8];
                        state_d     = S_GAP1;
                    end
                end
                S_GAP1: begin
                    state_d = S_WR;
                end
                S_WR: begin
                    if (ready) begin
                        i_d     = i_q + 1'b1;
                        state_d = S_GAP2;
                    end
                end
                S_GAP2: begin
                    if (i_q == total_q) begin
                        a0_d    = a2_q;
                        pc_d    = ra_q[PCW-1:0];
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end
    end

    // Outputs (Moore): bus is driven only in RD and WR.
    always_comb begin
        valid = 1'b0;
        write = 1'b0;
        size  = 3'd0;
        addr  = '0;
        wdata = '0;
        idle  = 1'b0;
        case (state_q)
            S_RD: begin
                valid = 1'b1;
                addr  = rd_addr;
            end
            S_WR: begin
                valid = 1'b1;
                write = 1'b1;
                addr  = a3_q;
                wdata = {24'b0, data_byte_q};
            end
            S_DONE: begin
                idle = 1'b1;
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hello_world.sv
// tb/tb_hello_world.sv - self-checking bench for hello_world

module tb_hello_world;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        setb = 1'b0;
    logic        idle;
    logic [7:0]  pc0 = 8'h80;
    logic [31:0] ra0 = 32'hEC;
    logic [31:0] sp0 = 32'h2000;
    logic [31:0] s00 = 32'h0;
    logic [31:0] a00 = 32'h0;
    logic [31:0] a10 = 32'h0;
    logic [31:0] a20 = 32'h0;
    logic [31:0] a30 = 32'h0;
    logic [31:0] a40 = 32'h0;
    logic [31:0] a50 = 32'h0;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        valid;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    always #5 clk = ~clk;

    hello_world #(.PCW(8), .XLEN(32)) dut (
        .clk(clk), .rstb(rstb), .setb(setb), .idle(idle),
        .pc0(pc0), .ra0(ra0), .sp0(sp0), .s00(s00),
        .a00(a00), .a10(a10), .a20(a20), .a30(a30), .a40(a40), .a50(a50),
        .addr(addr), .size(size), .valid(valid), .write(write), .wdata(wdata),
        .rdata(rdata), .ready(ready)
    );

    int tests = 0;
    int failed = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Byte-addressed memory (low 16 address bits) and a slave whose ready
    // is registered one cycle after a request, optionally stalled on writes.
    logic [7:0] mem [0:65535];
    logic       rdy_q;
    logic       stall = 1'b0;

    function automatic logic [7:0] mem_at(input logic [31:0] a);
        return mem[a[15:0]];
    endfunction

    always_comb begin
        rdata = {mem_at({addr[31:2], 2'b11}), mem_at({addr[31:2], 2'b10}),
                 mem_at({addr[31:2], 2'b01}), mem_at({addr[31:2], 2'b00})};
    end

    always @(posedge clk or negedge rstb) begin
        if (!rstb) rdy_q <= 1'b0;
        else       rdy_q <= valid && !rdy_q && !(write && stall);
    end
    assign ready = rdy_q;

    // TTY log: every accepted write.
    logic [7:0]  tty_d [$];
    logic [31:0] tty_a [$];
    always @(posedge clk) begin
        if (rstb && valid && ready && write) begin
            tty_d.push_back(wdata[7:0]);
            tty_a.push_back(addr);
        end
    end

    // Model: the k-th byte of a run is mem[ptr+k]; it goes to stream.
    // With k writes completed, the bus must show read of ptr+k or write of that byte.
    logic        model_en = 1'b0;
    logic [31:0] exp_ptr = 0;
    logic [31:0] exp_stream = 0;
    int          exp_total = 0;

    always @(negedge clk) begin
        if (rstb && valid) begin
            int idx;
            idx = tty_d.size();
            if (!model_en) begin
                check("spurious_valid", {31'b0, valid}, 32'h0);
            end else if (idx >= exp_total) begin
                check("extra_xfer", idx, exp_total - 1);
            end else begin
                check("bus_size", {29'b0, size}, 32'h0);
                if (write) begin
                    check("wr_addr", addr, exp_stream);
                    check("wr_data", wdata, {24'b0, mem_at(exp_ptr + idx)});
                end else begin
                    check("rd_addr", addr, exp_ptr + idx);
                end
            end
        end
    end

    task automatic start(input logic [31:0] p, input logic [31:0] sz,
                         input logic [31:0] n, input logic [31:0] st);
        @(posedge clk); #1;
        setb = 1'b0;
        a00 = p; a10 = sz; a20 = n; a30 = st;
        repeat (2) @(posedge clk);
        #1;
        tty_d.delete();
        tty_a.delete();
        exp_ptr = p;
        exp_stream = st;
        exp_total = int'(sz * n);
        model_en = 1'b1;
        setb = 1'b1;
    endtask

    task automatic wait_idle(input int limit);
        int c;
        c = 0;
        while (!idle && c < limit) begin
            @(negedge clk);
            c++;
        end
        check("idle_reached", {31'b0, idle}, 32'h1);
    endtask

    task automatic finish_run(input logic [31:0] exp_a0, input int exp_cnt);
        check("ret_a0", dut.a0, exp_a0);
        check("wr_count", tty_d.size(), exp_cnt);
        @(posedge clk); #1;
        setb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_falls", {31'b0, idle}, 32'h0);
        model_en = 1'b0;
    endtask

    string msg = "shit! urmom is so fat\n";

    initial begin
        logic [31:0] hold_addr;
        logic [31:0] hold_wdata;
        int          c;

        for (int k = 0; k < 65536; k++) mem[k] = 8'hEE;
        for (int k = 0; k < msg.len(); k++) mem[16'h1100 + k] = msg[k];

        // Reset state, checked without a clock edge
        #1 rstb = 1'b0;
        #1;
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_idle", {31'b0, idle}, 32'h0);
        check("rst_write", {31'b0, write}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_size", {29'b0, size}, 32'h0);
        check("rst_a0", dut.a0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rstb = 1'b1;

        // Main scenario: the 22-byte message to the TTY
        start(32'h1100, 32'd1, 32'd22, 32'h3000);
        wait_idle(400);
        for (int k = 0; k < 22 && k < tty_d.size(); k++) begin
            check("main_byte", tty_d[k], msg[k]);
            check("main_dest", tty_a[k], 32'h3000);
        end
        if (tty_d.size() == 22) begin
            check("main_first", tty_d[0], 8'h73);
            check("main_bang", tty_d[4], 8'h21);
            check("main_last", tty_d[21], 8'h0A);
        end
        check("ret_pc", dut.pc_q, 32'hEC);
        finish_run(32'd22, 22);

        // nmemb = 0 and size = 0: no bus activity, quick return of 0
        start(32'h1100, 32'd1, 32'd0, 32'h3000);
        wait_idle(3);
        finish_run(32'd0, 0);
        start(32'h1100, 32'd0, 32'd5, 32'h3000);
        wait_idle(3);
        finish_run(32'd0, 0);

        // Unaligned source: bytes 0x1103..0x1108 = "t! urm"
        start(32'h1103, 32'd2, 32'd3, 32'h3000);
        wait_idle(200);
        if (tty_d.size() == 6) begin
            check("ua_b0", tty_d[0], 8'h74);
            check("ua_b1", tty_d[1], 8'h21);
            check("ua_b2", tty_d[2], 8'h20);
            check("ua_b3", tty_d[3], 8'h75);
            check("ua_b4", tty_d[4], 8'h72);
            check("ua_b5", tty_d[5], 8'h6D);
        end
        finish_run(32'd3, 6);

        // TTY stall: first write held off for 1000 cycles
        stall = 1'b1;
        start(32'h1100, 32'd2, 32'd2, 32'h3000);
        c = 0;
        while (!(valid && write) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("stall_wr_seen", {31'b0, valid && write}, 32'h1);
        hold_addr = addr;
        hold_wdata = wdata;
        repeat (1000) @(negedge clk);
        check("stall_valid", {31'b0, valid}, 32'h1);
        check("stall_write", {31'b0, write}, 32'h1);
        check("stall_addr", addr, hold_addr);
        check("stall_wdata", wdata, hold_wdata);
        check("stall_noacc", tty_d.size(), 0);
        stall = 1'b0;
        wait_idle(200);
        if (tty_d.size() == 4) begin
            check("st_b0", tty_d[0], 8'h73);
            check("st_b1", tty_d[1], 8'h68);
            check("st_b2", tty_d[2], 8'h69);
            check("st_b3", tty_d[3], 8'h74);
        end
        finish_run(32'd2, 4);

        // Mid-run abort after 5 bytes, then a full restart from byte 0
        start(32'h1100, 32'd1, 32'd22, 32'h3000);
        c = 0;
        while (tty_d.size() < 5 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        check("abort_reach5", tty_d.size(), 5);
        setb = 1'b0;
        model_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", {31'b0, valid}, 32'h0);
        check("abort_idle", {31'b0, idle}, 32'h0);
        start(32'h1100, 32'd1, 32'd22, 32'h3000);
        wait_idle(400);
        if (tty_d.size() > 0) check("restart_first", tty_d[0], 8'h73);
        finish_run(32'd22, 22);

        // Asynchronous reset mid-run
        start(32'h1100, 32'd1, 32'd22, 32'h3000);
        c = 0;
        while (!(tty_d.size() >= 3 && valid) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("rst_mid_busy", {31'b0, valid}, 32'h1);
        #1 rstb = 1'b0;
        #1;
        check("arst_valid", {31'b0, valid}, 32'h0);
        check("arst_idle", {31'b0, idle}, 32'h0);
        check("arst_addr", addr, 32'h0);
        check("arst_a0", dut.a0, 32'h0);
        model_en = 1'b0;
        setb = 1'b0;
        @(posedge clk); #1;
        rstb = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {31'b0, idle}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
